// File: rtl/irq_controller_pkg.sv
// Shared types and constants for the interrupt controller (package irq_pkg).
// Build option: IRQ_SYNC_EN adds a 2-flop input synchronizer per source.
package irq_pkg;

  localparam int NSRC_DEFAULT = 4;
  localparam logic [15:0] MASK_RESET = '1;

  // Cycles after reset release before an edge detector trusts its history.
  localparam int SYNC_ARM_ON  = 3;
  localparam int SYNC_ARM_OFF = 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    SERVICE = 2'd2
  } irqState_t;

  function automatic int lowestIdx(input logic [15:0] vec);
    lowestIdx = 0;
    for (int i = 15; i >= 0; i--) begin
      if (vec[i]) lowestIdx = i;
    end
  endfunction

endpackage

// File: rtl/irq_controller_if.sv
// Processor-facing bundle of the interrupt controller: raw sources, mask port,
// and the request/acknowledge/return handshake.
interface irq_controller_if #(
  parameter int NSRC = irq_pkg::NSRC_DEFAULT,
  parameter int IDW  = $clog2(NSRC)
);
  // Handshake: ExtIRQ is held high with a stable irq_id until a one-cycle ack
  // is seen; the controller then stays quiet until a one-cycle eret closes the
  // round. ack outside a request and eret outside a service window are ignored.
  logic [NSRC-1:0] irq_in;
  logic            mask_we;
  logic [NSRC-1:0] mask_wdata;
  logic            ack;
  logic            eret;
  logic            ExtIRQ;
  logic [IDW-1:0]  irq_id;
  logic [NSRC-1:0] pending;

  modport master (
    output irq_in, mask_we, mask_wdata, ack, eret,
    input  ExtIRQ, irq_id, pending
  );

  modport slave (
    input  irq_in, mask_we, mask_wdata, ack, eret,
    output ExtIRQ, irq_id, pending
  );
endinterface

// File: rtl/irq_controller_sync_edge.sv
// Per-source rising-edge detector; with IRQ_SYNC_EN defined the raw line first
// passes through a 2-flop synchronizer.
module irq_sync_edge
  import irq_pkg::*;
(
  input  logic CLOCK_50,
  input  logic reset,
  input  logic irqRaw,
  output logic rise
);

`ifdef IRQ_SYNC_EN
  localparam int ARM = SYNC_ARM_ON;
  logic meta;
  logic syncNow;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      meta    <= 1'b0;
      syncNow <= 1'b0;
    end else begin
      meta    <= irqRaw;
      syncNow <= meta;
    end
  end
`else
  localparam int ARM = SYNC_ARM_OFF;
  logic syncNow;
  assign syncNow = irqRaw;
`endif

  logic       syncPrev;
  logic [1:0] armCnt;

  // Edges stay suppressed until syncPrev holds a sample taken after reset, so a
  // line already high at reset release is not mistaken for a new request.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      syncPrev <= 1'b0;
      armCnt   <= 2'd0;
    end else begin
      syncPrev <= syncNow;
      if (armCnt != 2'(ARM)) armCnt <= armCnt + 2'd1;
    end
  end

  assign rise = syncNow & ~syncPrev & (armCnt == 2'(ARM));

endmodule

// File: rtl/irq_controller.sv
// Prioritised interrupt controller: edge-latched pending bits, mask, and a
// request/service FSM toward the processor. Build option: IRQ_SYNC_EN.
module irq_controller
  import irq_pkg::*;
#(
  parameter int NSRC = NSRC_DEFAULT,
  parameter int IDW  = $clog2(NSRC)
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  irq_controller_if.slave  bus,
  output irqState_t        dbgState,
  output logic [NSRC-1:0]  dbgMask
);

  irqState_t       state, stateNext;
  logic [NSRC-1:0] pend, pendNext;
  logic [NSRC-1:0] mask;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] eligible;
  logic [IDW-1:0]  irqId, irqIdNext;

  for (genvar g = 0; g < NSRC; g++) begin : gSrc
    irq_sync_edge uSync (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .irqRaw   (bus.irq_in[g]),
      .rise     (rise[g])
    );
  end

  assign eligible = pend & mask;

  always_comb begin
    stateNext = state;
    irqIdNext = irqId;
    pendNext  = pend;
    case (state)
      IDLE: begin
        if (|eligible) begin
          irqIdNext = IDW'(lowestIdx(16'(eligible)));
          stateNext = ASSERT;
        end
      end
      ASSERT: begin
        if (bus.ack) begin
          pendNext[irqId] = 1'b0;
          stateNext       = SERVICE;
        end
      end
      SERVICE: begin
        if (bus.eret) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
    // Applied after the ack clear so a same-cycle edge keeps the bit set.
    pendNext = pendNext | rise;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state <= IDLE;
      pend  <= '0;
      mask  <= MASK_RESET[NSRC-1:0];
      irqId <= '0;
    end else begin
      state <= stateNext;
      pend  <= pendNext;
      irqId <= irqIdNext;
      if (bus.mask_we) mask <= bus.mask_wdata;
    end
  end

  assign bus.ExtIRQ  = (state == ASSERT);
  assign bus.irq_id  = irqId;
  assign bus.pending = pend;
  assign dbgState    = state;
  assign dbgMask     = mask;

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: cycle-level reference model with an expected queue,
// plus directed scenarios with hand-computed expectations.
module tb_irq_controller;
  import irq_pkg::*;

  localparam int NSRC = 4;
  localparam int IDW  = 2;
`ifdef IRQ_SYNC_EN
  localparam int D = 2;
`else
  localparam int D = 0;
`endif
  localparam int LAT = D + 1;
  localparam int W   = 13;

  // ---------------- clock / reset ----------------
  logic CLOCK_50 = 1'b0;
  logic reset    = 1'b1;
  always #10 CLOCK_50 = ~CLOCK_50;

  irqState_t       dbgState;
  logic [NSRC-1:0] dbgMask;

  irq_controller_if #(.NSRC(NSRC), .IDW(IDW)) bus ();

  irq_controller #(.NSRC(NSRC), .IDW(IDW)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus),
    .dbgState (dbgState),
    .dbgMask  (dbgMask)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [W-1:0]    exp_q[$];
  logic [NSRC-1:0] hist[$];
  int              mPhase = 0;
  logic [NSRC-1:0] mPend  = '0;
  logic [NSRC-1:0] mMask  = '1;
  logic [IDW-1:0]  mId    = '0;

  always @(posedge CLOCK_50) begin : model
    logic [NSRC-1:0] mRise;
    logic [NSRC-1:0] elig;
    if (reset) begin
      mPhase = 0;
      mPend  = '0;
      mMask  = '1;
      mId    = '0;
      hist.delete();
    end else begin
      hist.push_back(bus.irq_in);
      mRise = '0;
      if (hist.size() >= D + 2)
        mRise = hist[hist.size()-1-D] & ~hist[hist.size()-2-D];
      elig = mPend & mMask;
      if (mPhase == 0) begin
        if (elig != '0) begin
          for (int i = NSRC - 1; i >= 0; i--) if (elig[i]) mId = IDW'(i);
          mPhase = 1;
        end
      end else if (mPhase == 1) begin
        if (bus.ack) begin
          mPend[mId] = 1'b0;
          mPhase     = 2;
        end
      end else if (bus.eret) begin
        mPhase = 0;
      end
      mPend = mPend | mRise;
      if (bus.mask_we) mMask = bus.mask_wdata;
      if (hist.size() > 8) void'(hist.pop_front());
    end
    exp_q.push_back({(mPhase == 1), mId, mPend, mMask, 2'(mPhase)});
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge CLOCK_50) begin : compare
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("m_ExtIRQ",  32'(bus.ExtIRQ),  32'(e[12]));
      chk("m_irq_id",  32'(bus.irq_id),  32'(e[11:10]));
      chk("m_pending", 32'(bus.pending), 32'(e[9:6]));
      chk("m_mask",    32'(dbgMask),     32'(e[5:2]));
      chk("m_state",   32'(dbgState),    32'(e[1:0]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic pulseAck();
    bus.ack = 1'b1;
    step(1);
    bus.ack = 1'b0;
  endtask

  task automatic pulseEret();
    bus.eret = 1'b1;
    step(1);
    bus.eret = 1'b0;
  endtask

  task automatic writeMask(input logic [NSRC-1:0] m);
    bus.mask_we    = 1'b1;
    bus.mask_wdata = m;
    step(1);
    bus.mask_we    = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    bus.irq_in     = '0;
    bus.mask_we    = 1'b0;
    bus.mask_wdata = '0;
    bus.ack        = 1'b0;
    bus.eret       = 1'b0;
    reset          = 1'b1;
    step(3);
    reset = 1'b0;
    chk("rst_ext",   32'(bus.ExtIRQ),  32'd0);
    chk("rst_pend",  32'(bus.pending), 32'h0);
    chk("rst_mask",  32'(dbgMask),     32'hf);
    chk("rst_id",    32'(bus.irq_id),  32'd0);
    chk("rst_state", 32'(dbgState),    32'(IDLE));
    step(5);

    // single edge on source 2, exact latency
    bus.irq_in[2] = 1'b1;
    step(LAT);
    chk("s1_early", 32'(bus.ExtIRQ), 32'd0);
    step(1);
    chk("s1_ext",  32'(bus.ExtIRQ),  32'd1);
    chk("s1_id",   32'(bus.irq_id),  32'd2);
    chk("s1_pend", 32'(bus.pending), 32'h4);
    pulseAck();
    chk("s1_ack_ext",  32'(bus.ExtIRQ),  32'd0);
    chk("s1_ack_pend", 32'(bus.pending), 32'h0);
    chk("s1_ack_st",   32'(dbgState),    32'(SERVICE));
    pulseEret();
    chk("s1_eret_st", 32'(dbgState), 32'(IDLE));
    bus.irq_in = '0;
    step(4);

    // priority: sources 1 and 3 together
    bus.irq_in = 4'b1010;
    step(LAT + 1);
    chk("s2_ext",  32'(bus.ExtIRQ),  32'd1);
    chk("s2_id",   32'(bus.irq_id),  32'd1);
    chk("s2_pend", 32'(bus.pending), 32'ha);
    pulseAck();
    chk("s2_ack_pend", 32'(bus.pending), 32'h8);
    pulseEret();
    chk("s2_eret_ext", 32'(bus.ExtIRQ), 32'd0);
    step(1);
    chk("s2_next_ext", 32'(bus.ExtIRQ), 32'd1);
    chk("s2_next_id",  32'(bus.irq_id), 32'd3);
    pulseAck();
    pulseEret();
    bus.irq_in = '0;
    step(4);

    // masking holds a pending source until unmasked
    writeMask(4'b1110);
    chk("s3_mask", 32'(dbgMask), 32'he);
    bus.irq_in[0] = 1'b1;
    step(LAT + 3);
    chk("s3_pend", 32'(bus.pending), 32'h1);
    chk("s3_ext",  32'(bus.ExtIRQ),  32'd0);
    writeMask(4'b1111);
    chk("s3_unmask_ext0", 32'(bus.ExtIRQ), 32'd0);
    step(1);
    chk("s3_unmask_ext", 32'(bus.ExtIRQ), 32'd1);
    chk("s3_unmask_id",  32'(bus.irq_id), 32'd0);
    pulseAck();
    pulseEret();
    bus.irq_in = '0;
    step(4);

    // edge on source 0 in the very cycle its ack clears it
    bus.irq_in[0] = 1'b1;
    step(LAT + 1);
    chk("s4_ext", 32'(bus.ExtIRQ), 32'd1);
    bus.irq_in[0] = 1'b0;
    step(3);
    chk("s4_hold_ext", 32'(bus.ExtIRQ), 32'd1);
    bus.irq_in[0] = 1'b1;
    step(D);
    pulseAck();
    chk("s4_pend", 32'(bus.pending), 32'h1);
    chk("s4_st",   32'(dbgState),    32'(SERVICE));
    chk("s4_ext0", 32'(bus.ExtIRQ),  32'd0);
    pulseEret();
    step(1);
    chk("s4_re_ext", 32'(bus.ExtIRQ), 32'd1);
    chk("s4_re_id",  32'(bus.irq_id), 32'd0);
    pulseAck();
    pulseEret();
    bus.irq_in = '0;
    step(4);

    // reset while in SERVICE, sources held high across release
    writeMask(4'b1011);
    bus.irq_in[3] = 1'b1;
    step(LAT + 1);
    chk("s5_id", 32'(bus.irq_id), 32'd3);
    pulseAck();
    bus.irq_in[1] = 1'b1;
    step(LAT + 1);
    chk("s5_svc_pend", 32'(bus.pending), 32'h2);
    chk("s5_svc_ext",  32'(bus.ExtIRQ),  32'd0);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("s5_rst_ext",  32'(bus.ExtIRQ),  32'd0);
    chk("s5_rst_pend", 32'(bus.pending), 32'h0);
    chk("s5_rst_mask", 32'(dbgMask),     32'hf);
    chk("s5_rst_st",   32'(dbgState),    32'(IDLE));
    step(8);
    chk("s5_held_ext",  32'(bus.ExtIRQ),  32'd0);
    chk("s5_held_pend", 32'(bus.pending), 32'h0);
    bus.irq_in = '0;
    step(4);

    // stray handshakes
    pulseAck();
    chk("s6_ack_st",  32'(dbgState),    32'(IDLE));
    chk("s6_ack_ext", 32'(bus.ExtIRQ),  32'd0);
    bus.irq_in[2] = 1'b1;
    step(LAT + 1);
    chk("s6_ext", 32'(bus.ExtIRQ), 32'd1);
    pulseEret();
    chk("s6_eret_st",  32'(dbgState),   32'(ASSERT));
    chk("s6_eret_ext", 32'(bus.ExtIRQ), 32'd1);
    chk("s6_eret_id",  32'(bus.irq_id), 32'd2);
    pulseAck();
    pulseEret();
    bus.irq_in = '0;
    step(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 The block SHALL take parameter NSRC, default 4, the number of external interrupt sources (2..16).
REQ-002 The block SHALL take parameter IDW, default $clog2(NSRC), the width of the source-ID output.
REQ-003 Port CLOCK_50  input  1  the single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port irq_in  input  NSRC  raw asynchronous interrupt request lines, rising-edge triggered.
REQ-006 Port mask_we  input  1  write strobe for the mask register.
REQ-007 Port mask_wdata  input  NSRC  new mask value; bit=1 enables the source.
REQ-008 Port ack  input  1  processor has taken the exception (one-cycle pulse).
REQ-009 Port eret  input  1  processor has returned from the handler (one-cycle pulse).
REQ-010 Port ExtIRQ  output  1  interrupt request to processor_arm.
REQ-011 Port irq_id  output  IDW  index of the source being requested or serviced.
REQ-012 Port pending  output  NSRC  current pending register, for software readback.

Function
REQ-013 The block SHALL detect a rising edge per source as sync_now & ~sync_prev and set pending[i] on that edge.
REQ-014 The block SHALL run the FSM IDLE -> ASSERT -> SERVICE -> IDLE.
REQ-015 IDLE: if any (pending & mask) bit is set, the block SHALL latch the lowest-index such bit into irq_id and go to ASSERT next cycle.
REQ-016 ASSERT: ExtIRQ SHALL be 1 (combinational from state); on ack the block SHALL clear pending[irq_id] and go to SERVICE.
REQ-017 SERVICE: ExtIRQ SHALL be 0 and no new request SHALL be raised; on eret the block SHALL go to IDLE.
REQ-018 irq_id SHALL hold stable throughout ASSERT and SERVICE.
REQ-019 An edge on source i in the same cycle as its pending clear by ack SHALL win: pending[i] remains 1.
REQ-020 A mask write in ASSERT SHALL NOT retract ExtIRQ; masking affects only selection in IDLE.
REQ-021 A mask write takes effect in the following cycle; a masked pending bit SHALL stay pending and is served once unmasked.
REQ-022 ack outside ASSERT and eret outside SERVICE SHALL be ignored.
REQ-023 Simultaneous edges SHALL set all corresponding pending bits; they are served in ascending index order, one per ack/eret round.
REQ-024 Latency with synchronizer: an irq_in rise before edge 0 SHALL give ExtIRQ=1 after edge 3; without it, after edge 1.

Reset
REQ-025 On reset the block SHALL set state=IDLE, pending=0, mask=all ones, irq_id=0, synchronizer and sync_prev flops=0, and ExtIRQ=0.
REQ-026 Reset asserted mid-ASSERT or mid-SERVICE SHALL abort to IDLE and discard pending requests.
REQ-027 A source held high across reset release SHALL NOT produce a request; only a new rising edge does.

Configuration
REQ-028 Macro IRQ_SYNC_EN defined: each irq_in bit SHALL pass through a 2-flop synchronizer before edge detection.
REQ-029 Macro IRQ_SYNC_EN undefined: irq_in SHALL feed edge detection directly (sync_now=irq_in), giving the shorter latency in REQ-024.

Structure
REQ-030 The shared package irq_pkg SHALL hold the state enum typedef (IDLE, ASSERT, SERVICE) and the constants NSRC_DEFAULT=4 and MASK_RESET='1.
REQ-031 One sub-module, irq_sync_edge (per-bit synchronizer plus edge detector, honouring IRQ_SYNC_EN), SHALL be instantiated NSRC times.

Verification
REQ-032 The bench SHALL cover the single edge: irq_in[2] rises, IRQ_SYNC_EN on -> ExtIRQ=1 after edge 3, irq_id=2; ack -> ExtIRQ=0, pending[2]=0; eret -> IDLE.
REQ-033 The bench SHALL cover priority: irq_in[1] and irq_in[3] rise together -> id 1 served first; after eret, ExtIRQ=1 with irq_id=3.
REQ-034 The bench SHALL cover masking: mask=4'b1110, irq_in[0] rises -> pending=4'b0001, ExtIRQ=0; mask=4'b1111 -> ExtIRQ=1 with irq_id=0 two cycles later.
REQ-035 The bench SHALL cover edge/ack collision: a second irq_in[0] edge in the ack cycle -> pending[0]=1 in SERVICE and re-requested after eret.
REQ-036 The bench SHALL cover reset mid-SERVICE: reset for 1 cycle -> ExtIRQ=0, pending=0, mask=4'b1111; irq_in held high -> no request.
REQ-037 The bench SHALL cover stray handshakes: ack in IDLE and eret in ASSERT -> no state change, ExtIRQ unchanged.
